vrf_banked_arb: RTL and testbench

- Next-generation lane vector register file.
- Storage is split into BANK_NUM interleaved banks. Each bank accepts one write per cycle.
- Concurrent write ports are arbitrated per bank with round-robin priority and a valid/ready handshake.
- Read ports have a two-stage pipeline: a memory stage followed by an output-register stage gated by oreg_ren. The block sits between the lane issue/ALU/load units and the lane datapath.

---
 rtl/vrf_banked_arb.sv | 144 ++++++++++++++
 tb/tb_vrf_banked_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_banked_arb.sv
// Banked lane vector register file: round-robin write arbitration per bank, two-stage read pipeline.
// Optional VRF_WR_BYPASS_EN: same-cycle write-to-read forwarding in the memory stage (write-first).
module vrf_banked_arb #(
    parameter int R_PORTS_NUM = 8,
    parameter int W_PORTS_NUM = 4,
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_WIDTH   = 32,
    parameter int BANK_NUM    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [R_PORTS_NUM*$clog2(MEM_DEPTH)-1:0] raddr,
    input  logic [R_PORTS_NUM-1:0]                 ren,
    input  logic [R_PORTS_NUM-1:0]                 oreg_ren,
    output logic [R_PORTS_NUM*MEM_WIDTH-1:0]       data_o,
    input  logic [W_PORTS_NUM*$clog2(MEM_DEPTH)-1:0] waddr,
    input  logic [W_PORTS_NUM*MEM_WIDTH-1:0]       wdata,
    input  logic [W_PORTS_NUM*(MEM_WIDTH/8)-1:0]   bwen,
    input  logic [W_PORTS_NUM-1:0]                 wvalid,
    output logic [W_PORTS_NUM-1:0]                 wready,
    output logic [15:0]                            conflict_cnt
);
    localparam int AW         = $clog2(MEM_DEPTH);
    localparam int BW         = MEM_WIDTH / 8;
    localparam int LB         = $clog2(BANK_NUM);
    localparam int BSW        = (LB > 0) ? LB : 1;
    localparam int RW         = AW - LB;
    localparam int BANK_DEPTH = MEM_DEPTH / BANK_NUM;
    localparam int PW         = (W_PORTS_NUM > 1) ? $clog2(W_PORTS_NUM) : 1;

    function automatic logic [BSW-1:0] bank_of(input logic [AW-1:0] a);
        if (LB == 0) return '0;
        return BSW'(a);
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        return RW'(a >> LB);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [MEM_WIDTH-1:0] mem [BANK_NUM][BANK_DEPTH];

    logic [PW-1:0]        ptr_q [BANK_NUM];
    logic [PW-1:0]        ptr_d [BANK_NUM];
    logic [BANK_NUM-1:0]  gnt_vld;
    logic [RW-1:0]        wr_row  [BANK_NUM];
    logic [MEM_WIDTH-1:0] wr_data [BANK_NUM];
    logic [BW-1:0]        wr_ben  [BANK_NUM];
    logic [W_PORTS_NUM-1:0] wready_c;
    logic [15:0]          cnt_q;
    logic [15:0]          cnt_d;

    logic [MEM_WIDTH-1:0] rdata_p0_q [R_PORTS_NUM];
    logic [MEM_WIDTH-1:0] rdata_p0_d [R_PORTS_NUM];
    logic [MEM_WIDTH-1:0] dout_p1_q  [R_PORTS_NUM];
    logic [MEM_WIDTH-1:0] dout_p1_d  [R_PORTS_NUM];

    // Round-robin: pass 0 scans ports at/after ptr, pass 1 wraps to ports below ptr.
    always_comb begin
        wready_c = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            gnt_vld[b] = 1'b0;
            wr_row[b]  = '0;
            wr_data[b] = '0;
            wr_ben[b]  = '0;
            ptr_d[b]   = ptr_q[b];
            for (int pass = 0; pass < 2; pass++) begin
                for (int p = 0; p < W_PORTS_NUM; p++) begin
                    if (!rst && !gnt_vld[b] && wvalid[p]
                        && (bank_of(waddr[p*AW +: AW]) == BSW'(b))
                        && ((pass == 0) ? (p >= int'(ptr_q[b])) : (p < int'(ptr_q[b])))) begin
                        gnt_vld[b]  = 1'b1;
                        wready_c[p] = 1'b1;
                        wr_row[b]   = row_of(waddr[p*AW +: AW]);
                        wr_data[b]  = wdata[p*MEM_WIDTH +: MEM_WIDTH];
                        wr_ben[b]   = bwen[p*BW +: BW];
                        ptr_d[b]    = (p == W_PORTS_NUM - 1) ? '0 : PW'(p + 1);
                    end
                end
            end
        end
        cnt_d = (|(wvalid & ~wready_c)) ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BANK_NUM; b++) begin
            if (gnt_vld[b]) begin
                for (int i = 0; i < BW; i++) begin
                    if (wr_ben[b][i]) mem[b][wr_row[b]][i*8 +: 8] <= wr_data[b][i*8 +: 8];
                end
            end
        end
    end

    // Memory stage (p0) and output-register stage (p1)
    always_comb begin
        logic [BSW-1:0]       rbank;
        logic [RW-1:0]        rrow;
        logic [MEM_WIDTH-1:0] rword;
        for (int p = 0; p < R_PORTS_NUM; p++) begin
            rbank = bank_of(raddr[p*AW +: AW]);
            rrow  = row_of(raddr[p*AW +: AW]);
            rword = mem[rbank][rrow];
`ifdef VRF_WR_BYPASS_EN
            if (gnt_vld[rbank] && (wr_row[rbank] == rrow)) begin
                for (int i = 0; i < BW; i++) begin
                    if (wr_ben[rbank][i]) rword[i*8 +: 8] = wr_data[rbank][i*8 +: 8];
                end
            end
`endif
            rdata_p0_d[p] = ren[p] ? rword : rdata_p0_q[p];
            dout_p1_d[p]  = oreg_ren[p] ? rdata_p0_q[p] : dout_p1_q[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int b = 0; b < BANK_NUM; b++) ptr_q[b] <= '0;
            for (int p = 0; p < R_PORTS_NUM; p++) begin
                rdata_p0_q[p] <= '0;
                dout_p1_q[p]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int b = 0; b < BANK_NUM; b++) ptr_q[b] <= ptr_d[b];
            for (int p = 0; p < R_PORTS_NUM; p++) begin
                rdata_p0_q[p] <= rdata_p0_d[p];
                dout_p1_q[p]  <= dout_p1_d[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < R_PORTS_NUM; p++) data_o[p*MEM_WIDTH +: MEM_WIDTH] = dout_p1_q[p];
    end

    assign wready       = wready_c;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vrf_banked_arb.sv
// Directed bench for vrf_banked_arb with default parameters (8R/4W, 1024x32, 4 banks).
module tb_vrf_banked_arb;
    localparam int RP  = 8;
    localparam int WP  = 4;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int BWB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [RP*AW-1:0]  raddr;
    logic [RP-1:0]     ren;
    logic [RP-1:0]     oreg_ren;
    logic [RP*DW-1:0]  data_o;
    logic [WP*AW-1:0]  waddr;
    logic [WP*DW-1:0]  wdata;
    logic [WP*BWB-1:0] bwen;
    logic [WP-1:0]     wvalid;
    logic [WP-1:0]     wready;
    logic [15:0]       conflict_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_collide;

    always #5 clk = ~clk;

    vrf_banked_arb dut (
        .clk(clk), .rst(rst), .raddr(raddr), .ren(ren), .oreg_ren(oreg_ren),
        .data_o(data_o), .waddr(waddr), .wdata(wdata), .bwen(bwen),
        .wvalid(wvalid), .wready(wready), .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dout(input int p);
        return data_o[p*DW +: DW];
    endfunction

    task automatic set_w(input int p, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        waddr[p*AW +: AW]   = a;
        wdata[p*DW +: DW]   = d;
        bwen[p*BWB +: BWB]  = be;
        wvalid[p]           = 1'b1;
    endtask

    task automatic clear_w();
        wvalid = '0;
        bwen   = '0;
    endtask

    task automatic set_r(input int p, input logic [9:0] a);
        raddr[p*AW +: AW] = a;
        ren[p]            = 1'b1;
    endtask

    task automatic rd(input int p, input logic [9:0] a, input logic [31:0] exp, input string tag);
        set_r(p, a);
        tick();
        ren[p]      = 1'b0;
        oreg_ren[p] = 1'b1;
        tick();
        oreg_ren[p] = 1'b0;
        chk(tag, dout(p), exp);
    endtask

    initial begin
`ifdef VRF_WR_BYPASS_EN
        exp_collide = 32'hFFFF_FFFF;
`else
        exp_collide = 32'h0000_0000;
`endif
        rst = 1'b1; raddr = '0; ren = '0; oreg_ren = '0;
        waddr = '0; wdata = '0; bwen = '0; wvalid = '0;

        // Reset: a pending request must not be accepted
        set_w(0, 10'h005, 32'h0BAD_0BAD, 4'hF);
        #1 chk("rst_wready", wready, 4'b0000);
        tick(); tick();
        chk("rst_data_o", data_o, '0);
        chk("rst_cnt", conflict_cnt, 16'd0);
        clear_w();
        rst = 1'b0;
        tick();

        // Basic write then 2-cycle read
        set_w(0, 10'h005, 32'hDEAD_BEEF, 4'hF);
        #1 chk("t1_wready", wready, 4'b0001);
        tick();
        clear_w();
        set_r(3, 10'h005);
        tick();
        ren = '0;
        oreg_ren[3] = 1'b1;
        chk("t1_lat1", dout(3), 32'h0);
        tick();
        oreg_ren = '0;
        chk("t1_data", dout(3), 32'hDEAD_BEEF);

        // Bank-0 conflict: grants 0,1,2 in order
        set_w(0, 10'h004, 32'h0000_0100, 4'hF);
        set_w(1, 10'h008, 32'h0000_0200, 4'hF);
        set_w(2, 10'h00C, 32'h0000_0300, 4'hF);
        #1 chk("t2_gnt0", wready, 4'b0001);
        tick();
        wvalid[0] = 1'b0;
        #1 chk("t2_gnt1", wready, 4'b0010);
        tick();
        wvalid[1] = 1'b0;
        #1 chk("t2_gnt2", wready, 4'b0100);
        tick();
        clear_w();
        chk("t2_cnt", conflict_cnt, 16'd2);
        set_r(0, 10'h004); set_r(1, 10'h008); set_r(2, 10'h00C);
        tick();
        ren = '0; oreg_ren = 8'b0000_0111;
        tick();
        oreg_ren = '0;
        chk("t2_rd0", dout(0), 32'h0000_0100);
        chk("t2_rd1", dout(1), 32'h0000_0200);
        chk("t2_rd2", dout(2), 32'h0000_0300);

        // Parallel writes to four banks
        for (int p = 0; p < 4; p++) set_w(p, 10'(10'h010 + p), 32'hC0DE_0000 + p, 4'hF);
        #1 chk("t3_wready", wready, 4'b1111);
        tick();
        clear_w();
        chk("t3_cnt", conflict_cnt, 16'd2);
        for (int p = 0; p < 4; p++) set_r(4 + p, 10'(10'h010 + p));
        tick();
        ren = '0; oreg_ren = 8'b1111_0000;
        tick();
        oreg_ren = '0;
        chk("t3_rd0", dout(4), 32'hC0DE_0000);
        chk("t3_rd1", dout(5), 32'hC0DE_0001);
        chk("t3_rd2", dout(6), 32'hC0DE_0002);
        chk("t3_rd3", dout(7), 32'hC0DE_0003);

        // Byte enables, then an all-zero bwen request
        set_w(1, 10'h020, 32'h1122_3344, 4'hF);
        tick();
        clear_w();
        set_w(2, 10'h020, 32'hAABB_CCDD, 4'h5);
        #1 chk("t4_wready", wready, 4'b0100);
        tick();
        clear_w();
        rd(0, 10'h020, 32'h11BB_33DD, "t4_bytes");
        set_w(3, 10'h020, 32'h1234_5678, 4'h0);
        #1 chk("t4_zero_ben_wready", wready, 4'b1000);
        tick();
        clear_w();
        rd(0, 10'h020, 32'h11BB_33DD, "t4_zero_ben");

        // Same-cycle read/write collision
        set_w(0, 10'h030, 32'h0000_0000, 4'hF);
        tick();
        clear_w();
        set_w(3, 10'h030, 32'hFFFF_FFFF, 4'hF);
        set_r(5, 10'h030);
        #1 chk("t5_wready", wready, 4'b1000);
        tick();
        clear_w();
        ren = '0; oreg_ren[5] = 1'b1;
        tick();
        oreg_ren = '0;
        chk("t5_collide", dout(5), exp_collide);
        rd(5, 10'h030, 32'hFFFF_FFFF, "t5_after");

        // oreg_ren=0 holds data_o; ren=0 holds the memory stage
        set_r(3, 10'h020);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold", dout(3), 32'hDEAD_BEEF);
        end
        ren = '0;
        raddr[3*AW +: AW] = 10'h005;
        oreg_ren[3] = 1'b1;
        tick();
        oreg_ren = '0;
        chk("t6_release", dout(3), 32'h11BB_33DD);

        // Saturation: two requesters on bank 3 every cycle
        set_w(0, 10'h003, 32'h0000_0A0A, 4'hF);
        set_w(1, 10'h007, 32'h0000_0B0B, 4'hF);
        repeat (65540) @(posedge clk);
        #1 chk("t7_sat", conflict_cnt, 16'hFFFF);
        clear_w();
        tick();

        // Reset mid-operation: ptr[3] is left at 1 before reset
        set_w(0, 10'h003, 32'h0000_0C0C, 4'hF);
        tick();
        set_w(1, 10'h007, 32'h0000_0D0D, 4'hF);
        rst = 1'b1;
        #1 chk("t8_rst_wready", wready, 4'b0000);
        tick();
        chk("t8_rst_data", data_o, '0);
        chk("t8_rst_cnt", conflict_cnt, 16'd0);
        rst = 1'b0;
        #1 chk("t8_ptr_reset", wready, 4'b0001);
        tick();
        clear_w();
        oreg_ren[5] = 1'b1;
        tick();
        oreg_ren = '0;
        chk("t8_memstage_clr", dout(5), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
